// File: rtl/line_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_write_ctrl
// Purpose  : Writes a valid/ready RGB line stream into a two-bank line memory
//            and announces each completed line to the read side.
// Revision : 1.0  initial release
// ============================================================================
module line_write_ctrl #(
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [23:0]          s_data,
    input  logic                 s_sof,
    input  logic                 s_eol,
    output logic                 mem_wr,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [23:0]          mem_data,
    output logic                 line_done,
    output logic                 line_bank,
    output logic [ADDR_BITS-1:0] line_len,
    output logic [15:0]          line_num,
    input  logic                 rd_release,
    output logic                 err_long,
    output logic                 err_sof
);

    localparam int c_col_bits = ADDR_BITS - 1;
    localparam logic [ADDR_BITS-1:0] c_line_pix = {1'b1, {c_col_bits{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nx;
    logic                   r_ready;
    logic                   r_bank, w_bank_nx;
    logic [ADDR_BITS-1:0]   r_col, w_col_nx;
    logic [15:0]            r_line_cnt, w_cnt_nx;
    logic [1:0]             r_occ, w_occ_nx;

    logic                   r_mem_wr;
    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic [23:0]            r_mem_data;
    logic                   r_line_done, r_line_bank;
    logic [ADDR_BITS-1:0]   r_line_len;
    logic [15:0]            r_line_num;
    logic                   r_err_long, r_err_sof;

    logic                   w_beat, w_line_beat, w_eol, w_rel, w_fits;
    logic [ADDR_BITS-1:0]   w_col, w_col_inc;
    logic [15:0]            w_num;

    // Outside a frame only a sof beat starts a line; other beats are dropped.
    assign w_beat      = s_valid && r_ready;
    assign w_line_beat = w_beat && ((r_state == S_WRITE) || s_sof);
    assign w_eol       = w_line_beat && s_eol;
    assign w_rel       = rd_release && (r_occ != 2'd0);
    assign w_col       = s_sof ? '0 : r_col;
    assign w_num       = s_sof ? 16'd0 : r_line_cnt;
    assign w_fits      = (w_col != c_line_pix);
    assign w_col_inc   = w_fits ? w_col + 1'b1 : w_col;

    always_comb begin
        w_state_nx = r_state;
        w_bank_nx  = r_bank;
        w_col_nx   = r_col;
        w_cnt_nx   = r_line_cnt;
        w_occ_nx   = r_occ + {1'b0, w_eol} - {1'b0, w_rel};
        if (w_line_beat) begin
            w_col_nx = w_col_inc;
            w_cnt_nx = w_num;
            if (s_eol) begin
                w_bank_nx = ~r_bank;
                w_col_nx  = '0;
                w_cnt_nx  = w_num + 16'd1;
            end
        end
        case (r_state)
            S_IDLE:  if (w_line_beat) w_state_nx = S_WRITE;
            S_WAIT:  if (w_rel) w_state_nx = S_WRITE;
            default: w_state_nx = r_state;
        endcase
        if (w_occ_nx == 2'd2) w_state_nx = S_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_bank      <= 1'b0;
            r_col       <= '0;
            r_line_cnt  <= 16'd0;
            r_occ       <= 2'd0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= 24'd0;
            r_line_done <= 1'b0;
            r_line_bank <= 1'b0;
            r_line_len  <= '0;
            r_line_num  <= 16'd0;
            r_err_long  <= 1'b0;
            r_err_sof   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ready     <= (w_state_nx != S_WAIT);
            r_bank      <= w_bank_nx;
            r_col       <= w_col_nx;
            r_line_cnt  <= w_cnt_nx;
            r_occ       <= w_occ_nx;
            r_mem_wr    <= w_line_beat && w_fits;
            if (w_line_beat && w_fits) begin
                r_mem_addr <= {r_bank, w_col[c_col_bits-1:0]};
                r_mem_data <= s_data;
            end
            r_line_done <= w_eol;
            if (w_eol) begin
                r_line_bank <= r_bank;
                r_line_len  <= w_col_inc;
                r_line_num  <= w_num;
            end
            if (w_line_beat && !w_fits) r_err_long <= 1'b1;
            if (w_line_beat && s_sof && (r_col != '0)) r_err_sof <= 1'b1;
        end
    end

    assign s_ready   = r_ready;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign line_done = r_line_done;
    assign line_bank = r_line_bank;
    assign line_len  = r_line_len;
    assign line_num  = r_line_num;
    assign err_long  = r_err_long;
    assign err_sof   = r_err_sof;

endmodule
`default_nettype wire

// File: tb/tb_line_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_write_ctrl
// Purpose  : Scoreboard bench for line_write_ctrl at ADDR_BITS=11 and 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_line_write_ctrl;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_sof, s_eol, rd_release;
    logic [23:0] s_data;

    logic        rdy11, wr11, ld11, lb11, el11, es11;
    logic [10:0] ad11, ll11;
    logic [23:0] md11;
    logic [15:0] ln11;
    logic        rdy4, wr4, ld4, lb4, el4, es4;
    logic [3:0]  ad4, ll4;
    logic [23:0] md4;
    logic [15:0] ln4;

    always #5 clk = ~clk;

    line_write_ctrl #(.ADDR_BITS(11)) dut11 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy11), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .mem_wr(wr11), .mem_addr(ad11), .mem_data(md11),
        .line_done(ld11), .line_bank(lb11), .line_len(ll11), .line_num(ln11),
        .rd_release(rd_release), .err_long(el11), .err_sof(es11));

    line_write_ctrl #(.ADDR_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy4), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .mem_wr(wr4), .mem_addr(ad4), .mem_data(md4),
        .line_done(ld4), .line_bank(lb4), .line_len(ll4), .line_num(ln4),
        .rd_release(rd_release), .err_long(el4), .err_sof(es4));

    typedef struct packed { int addr; logic [23:0] data; } wr_t;
    typedef struct packed { int bank; int len; int num; } ln_t;

    wr_t wq0[$], wq1[$];
    ln_t lq0[$], lq1[$];
    ln_t held[2];
    int  n_err = 0, n_chk = 0;
    int  n_wr[2], n_ld[2];

    // Reference model: per-instance frame state plus shared bank occupancy.
    bit  mf_in[2], mf_bank[2], me_long[2], me_sof[2];
    int  mf_col[2], mf_num[2];
    int  occ;
    bit  m_ready, m_rst;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void push_wr(input int k, input wr_t e);
        if (k == 0) wq0.push_back(e); else wq1.push_back(e);
    endfunction
    function automatic void push_ln(input int k, input ln_t e);
        if (k == 0) lq0.push_back(e); else lq1.push_back(e);
    endfunction
    function automatic int wq_size(input int k);
        return (k == 0) ? wq0.size() : wq1.size();
    endfunction
    function automatic int lq_size(input int k);
        return (k == 0) ? lq0.size() : lq1.size();
    endfunction
    function automatic wr_t wq_pop(input int k);
        if (k == 0) return wq0.pop_front();
        return wq1.pop_front();
    endfunction
    function automatic ln_t lq_pop(input int k);
        if (k == 0) return lq0.pop_front();
        return lq1.pop_front();
    endfunction

    // Applies one accepted beat to instance k (bank size lp); returns 1 on a completed line.
    function automatic bit model_beat(input int k, input int lp, input logic [23:0] d,
                                      input bit sof, input bit eol);
        if (!mf_in[k] && !sof) return 1'b0;
        mf_in[k] = 1'b1;
        if (sof) begin
            if (mf_col[k] > 0) me_sof[k] = 1'b1;
            mf_col[k] = 0;
            mf_num[k] = 0;
        end
        if (mf_col[k] < lp) begin
            push_wr(k, '{addr: int'(mf_bank[k]) * lp + mf_col[k], data: d});
            mf_col[k]++;
        end else begin
            me_long[k] = 1'b1;
        end
        if (!eol) return 1'b0;
        push_ln(k, '{bank: int'(mf_bank[k]), len: mf_col[k], num: mf_num[k]});
        mf_bank[k] = ~mf_bank[k];
        mf_col[k]  = 0;
        mf_num[k]  = (mf_num[k] + 1) % 65536;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit done, rel;
        m_rst = rst;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mf_in[k] = 0; mf_bank[k] = 0; mf_col[k] = 0; mf_num[k] = 0;
                me_long[k] = 0; me_sof[k] = 0;
                held[k] = '{bank: 0, len: 0, num: 0};
            end
            wq0.delete(); wq1.delete(); lq0.delete(); lq1.delete();
            occ = 0;
            m_ready = 1'b0;
        end else begin
            done = 1'b0;
            if (s_valid && m_ready) begin
                done = model_beat(0, 1024, s_data, s_sof, s_eol);
                void'(model_beat(1, 8, s_data, s_sof, s_eol));
            end
            rel = rd_release && (occ > 0);
            occ = occ + int'(done) - int'(rel);
            m_ready = (occ != 2);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard half a cycle after each edge.
    always @(negedge clk) begin
        bit o_wr[2], o_ld[2], o_rd[2], o_el[2], o_es[2];
        int o_addr[2], o_data[2], o_lb[2], o_ll[2], o_ln[2], o_any[2];
        wr_t ew;
        ln_t el;
        o_wr = '{wr11, wr4};  o_ld = '{ld11, ld4};  o_rd = '{rdy11, rdy4};
        o_el = '{el11, el4};  o_es = '{es11, es4};
        o_addr = '{int'(ad11), int'(ad4)};  o_data = '{int'(md11), int'(md4)};
        o_lb = '{int'(lb11), int'(lb4)};    o_ll = '{int'(ll11), int'(ll4)};
        o_ln = '{int'(ln11), int'(ln4)};
        for (int k = 0; k < 2; k++) begin
            o_any[k] = int'(o_wr[k] || o_ld[k] || o_rd[k] || o_el[k] || o_es[k] ||
                            o_addr[k] != 0 || o_data[k] != 0 || o_lb[k] != 0 ||
                            o_ll[k] != 0 || o_ln[k] != 0);
            if (m_rst) chk("reset_outputs_zero", o_any[k], 0);
            chk("s_ready", int'(o_rd[k]), int'(m_ready));
            chk("err_long", int'(o_el[k]), int'(me_long[k]));
            chk("err_sof", int'(o_es[k]), int'(me_sof[k]));
            if (o_wr[k]) n_wr[k]++;
            if (o_ld[k]) n_ld[k]++;
            if (wq_size(k) != 0) begin
                ew = wq_pop(k);
                chk("mem_wr", int'(o_wr[k]), 1);
                if (o_wr[k]) begin
                    chk("mem_addr", o_addr[k], ew.addr);
                    chk("mem_data", o_data[k], int'(ew.data));
                end
            end else begin
                chk("mem_wr_idle", int'(o_wr[k]), 0);
            end
            if (lq_size(k) != 0) begin
                el = lq_pop(k);
                held[k] = el;
                chk("line_done", int'(o_ld[k]), 1);
            end else begin
                chk("line_done_idle", int'(o_ld[k]), 0);
            end
            chk("line_bank", o_lb[k], held[k].bank);
            chk("line_len", o_ll[k], held[k].len);
            chk("line_num", o_ln[k], held[k].num);
        end
    end

    task automatic cyc(input bit v, input logic [23:0] d, input bit sof, input bit eol,
                       input bit rel, output bit acc);
        s_valid = v; s_data = d; s_sof = sof; s_eol = eol; rd_release = rel;
        acc = v && m_ready;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    task automatic beat(input logic [23:0] d, input bit sof, input bit eol);
        bit acc;
        int t = 0;
        do begin
            cyc(1'b1, d, sof, eol, 1'b0, acc);
            t++;
        end while (!acc && t < 20);
        if (!acc) chk("beat_accept_timeout", int'(rdy11), 1);
    endtask

    initial begin
        bit a;
        int w0, l0;
        rst = 1'b1; s_valid = 0; s_data = 0; s_sof = 0; s_eol = 0; rd_release = 0;
        n_wr = '{0, 0}; n_ld = '{0, 0};
        idle(1);
        rst = 1'b0;
        idle(2);

        // Basic 4-pixel line.
        beat(24'h000001, 1, 0); beat(24'h000002, 0, 0);
        beat(24'h000003, 0, 0); beat(24'h000004, 0, 1);
        idle(3);

        // Two lines fill both banks; third line stalls until one release.
        do_reset();
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 3; i++) beat(24'h100 + l * 16 + i, (l == 0 && i == 0), i == 2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 24'h200, 1'b0, 1'b0, 1'b0, a);
        chk("stall_while_full", int'(rdy11), 0);
        cyc(1'b1, 24'h200, 1'b0, 1'b0, 1'b1, a);
        chk("ready_after_release", int'(rdy4), 1);
        beat(24'h200, 0, 0); beat(24'h201, 0, 0); beat(24'h202, 0, 1);
        idle(2);

        // eol coinciding with a release at occupancy 1: no stall.
        do_reset();
        beat(24'h300, 1, 0); beat(24'h301, 0, 1);
        beat(24'h310, 0, 0);
        cyc(1'b1, 24'h311, 1'b0, 1'b1, 1'b1, a);
        chk("eol_release_accepted", int'(a), 1);
        beat(24'h320, 0, 0); beat(24'h321, 0, 1);
        idle(2);

        // Overlong line then a normal one; err_long stays set on the small instance.
        do_reset();
        w0 = n_wr[1];
        for (int i = 0; i < 10; i++) beat(24'h400 + i, i == 0, i == 9);
        idle(2);
        chk("overlong_write_count", n_wr[1] - w0, 8);
        cyc(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        beat(24'h420, 0, 0); beat(24'h421, 0, 1);
        idle(2);
        chk("err_long_sticky", int'(el4), 1);

        // sof arrives mid-line.
        do_reset();
        l0 = n_ld[0];
        for (int i = 0; i < 3; i++) beat(24'h500 + i, i == 0, 0);
        beat(24'h510, 1, 0); beat(24'h511, 0, 1);
        idle(2);
        chk("sof_midline_one_line_done", n_ld[0] - l0, 1);

        // Reset mid-line: partial line discarded, non-sof beats dropped afterwards.
        do_reset();
        for (int i = 0; i < 5; i++) beat(24'h600 + i, i == 0, 0);
        do_reset();
        w0 = n_wr[0];
        for (int i = 0; i < 3; i++) beat(24'h700 + i, 0, 0);
        idle(1);
        chk("dropped_after_reset", n_wr[0] - w0, 0);
        beat(24'h710, 1, 0); beat(24'h711, 0, 1);
        idle(2);

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 99) < 70, 24'($urandom),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 99) < 25, a);
            end
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
